fetch_ctrl: RTL
===============

# fetch_ctrl

Pipeline fetch controller for the five-stage Y86-64 core. Owns the F-stage predicted-PC register, selects the PC presented to the fetch stage each cycle, and generates the stall/bubble controls for the F, D and E pipeline registers. These controls handle load/use hazards, `ret` and mispredicted conditional jumps. A drain state machine stops fetching once a halt, invalid-instruction or memory-error status is fetched, and reports when the core has halted.

## Interface
Parameters:
- RESET_PC, 64'd0, PC loaded into predPC on reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- f_icode  in  4  icode from fetch stage (current f_pc)
- f_ifun  in  4  ifun from fetch stage
- f_valC  in  64  constant word from fetch stage
- f_valP  in  64  incremented PC from fetch stage
- f_instr_valid  in  1  fetch decoded a legal icode
- f_imem_error  in  1  fetch address out of range
- f_hlt  in  1  fetch saw `halt`
- D_icode, E_icode, M_icode  in  4 each  icodes held in D/E/M pipeline registers
- d_srcA, d_srcB  in  4 each  decode source register IDs (0xF = none)
- E_dstM  in  4  load destination in E register
- e_Cnd  in  1  condition outcome computed in execute
- M_Cnd  in  1  condition outcome latched in M register
- M_valA  in  64  fall-through PC carried by a jump in M
- W_icode  in  4  icode in W register
- W_valM  in  64  return address read by `ret` in W
- W_stat  in  3  status in W register (1 AOK, 2 HLT, 3 ADR, 4 INS)
- f_pc  out  64  PC driven to fetch stage
- f_stat  out  3  status of the fetched instruction
- F_stall, D_stall, D_bubble, E_bubble  out  1 each  pipeline register controls
- halted  out  1  core halted; holds until reset

## Operation
- Icode encodings: HALT 0, JXX 7, CALL 8, RET 9, MRMOVQ 5, POPQ B.
- f_pc priority:
  - W_valM if W_icode==RET.
  - Else M_valA if M_icode==JXX and !M_Cnd.
  - Else predPC.
- f_stat priority: ADR if f_imem_error, else INS if !f_instr_valid, else HLT if f_hlt, else AOK.
- Hazard terms:
  - loaduse = E_icode∈{5,B} and E_dstM!=0xF and E_dstM∈{d_srcA,d_srcB}.
  - retpend = RET∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX and !e_Cnd.
- Controls:
  - F_stall = loaduse | retpend | (state!=RUN).
  - D_stall = loaduse.
  - D_bubble = mispred | (!loaduse & retpend) | (state==DRAIN & !mispred).
  - E_bubble = mispred | loaduse.
  - mispred overrides the drain bubble.
- predPC update, only when !F_stall:
  - f_valC if f_icode∈{JXX,CALL}, else f_valP.
  - All arithmetic is 64-bit and wraps modulo 2^64; there is no overflow handling.
- State machine (RUN, DRAIN, HALTED):
  - RUN→DRAIN when !F_stall and f_stat!=AOK and !mispred. The faulting instruction enters D this cycle; fetch freezes afterward.
  - DRAIN→RUN when mispred: the faulting instruction was on the wrong path. predPC←M_valA is not needed because f_pc selection handles redirect; predPC is reloaded from the redirected fetch next cycle.
  - DRAIN→HALTED when W_stat!=AOK.
  - HALTED is absorbing. All outputs are held: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
- halted = (state==HALTED).

## Timing
- f_pc, f_stat and all stall/bubble outputs are combinational from inputs and registered state, with zero-cycle latency.
- predPC and state update on the rising clk edge.
- Reset, synchronous, overriding everything including mid-drain:
  - predPC=RESET_PC, state=RUN.
  - Outputs the cycle after reset with quiescent inputs (all icodes NOP=1, W_stat=AOK): f_pc=RESET_PC, f_stat from fetch inputs, all stall/bubble=0, halted=0.
- Simultaneous loaduse and mispred: E_bubble=1, D_stall=1, D_bubble=1. Stall wins over bubble at the D register; the D register treats stall as dominant.
- Simultaneous RET in W and mispredicted JXX in M: W_valM has priority.
- `ret` penalty: 3 bubble cycles. Mispredict penalty: 2 cycles. Load/use: 1 stall cycle.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds four 32-bit saturating counters:
  - perf_cycles: cycles not halted.
  - perf_stalls: F_stall in RUN.
  - perf_mispred: mispred.
  - perf_ret: retpend.
  - Exposed as outputs perf_cycles, perf_stalls, perf_mispred, perf_ret; cleared by rst; frozen in HALTED.
- Undefined: those ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Sequential flow: reset with RESET_PC=0; f_icode=6, f_valP=2 -> next cycle f_pc=2; then f_icode=3, f_valP=12 -> f_pc=12.
- Jump mispredict: f_icode=7, f_valC=0x40, f_valP=0x0B -> f_pc=0x40. Then E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1. Next cycle M_icode=7, M_Cnd=0, M_valA=0x0B -> f_pc=0x0B.
- Load/use: E_icode=5, E_dstM=2, d_srcA=2 -> F_stall=D_stall=E_bubble=1, D_bubble=0, predPC unchanged. With E_dstM=0xF -> all controls 0.
- Ret: D_icode=9 for one cycle, then E and M -> F_stall=1, D_bubble=1 for 3 cycles. W_icode=9, W_valM=0x100 -> f_pc=0x100.
- Halt drain: f_hlt=1 -> state DRAIN, f_stat=2, F_stall=1 on later cycles. W_stat=2 -> halted=1 next cycle, held for 20 cycles. rst -> halted=0, f_pc=RESET_PC.
- Wrong-path halt: f_hlt fetched after a jump, then mispred asserts in DRAIN -> state RUN, F_stall=0, halted never asserts. f_imem_error=1 gives f_stat=3 regardless of f_hlt.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: pipeline-side signals exchanged with the Y86-64 fetch controller
interface fetch_ctrl_if;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_valC, f_valP;
  logic        f_instr_valid, f_imem_error, f_hlt;
  logic [3:0]  D_icode, E_icode, M_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_Cnd, M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  W_stat;
  logic [63:0] f_pc;
  logic [2:0]  f_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, halted;
  modport master (
    output f_icode, f_ifun, f_valC, f_valP, f_instr_valid, f_imem_error, f_hlt,
           D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, M_Cnd, M_valA,
           W_icode, W_valM, W_stat,
    input  f_pc, f_stat, F_stall, D_stall, D_bubble, E_bubble, halted
  );
  modport slave (
    input  f_icode, f_ifun, f_valC, f_valP, f_instr_valid, f_imem_error, f_hlt,
           D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, M_Cnd, M_valA,
           W_icode, W_valM, W_stat,
    output f_pc, f_stat, F_stall, D_stall, D_bubble, E_bubble, halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: Y86-64 fetch PC select, hazard stall/bubble and halt drain; FETCH_CTRL_PERF_EN adds perf counters
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input logic clk,
  input logic rst,
  fetch_ctrl_if.slave bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_mispred,
  output logic [31:0] perf_ret
`endif
);
  localparam logic [3:0] I_MRMOVQ = 4'h5, I_JXX = 4'h7, I_CALL = 4'h8, I_RET = 4'h9, I_POPQ = 4'hB, R_NONE = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nxt;
  logic [63:0] pred_pc, pred_pc_nxt;
  logic loaduse, retpend, mispred, halt;
  assign loaduse = (bus.E_icode == I_MRMOVQ || bus.E_icode == I_POPQ) && bus.E_dstM != R_NONE &&
                   (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  assign retpend = bus.D_icode == I_RET || bus.E_icode == I_RET || bus.M_icode == I_RET;
  assign mispred = bus.E_icode == I_JXX && !bus.e_Cnd;
  assign halt = state == HALTED;
  assign bus.halted = halt;
  // fetch address: ret target beats mispredict fall-through beats prediction
  always_comb begin
    bus.f_pc = bus.W_icode == I_RET ? bus.W_valM :
               (bus.M_icode == I_JXX && !bus.M_Cnd) ? bus.M_valA : pred_pc;
    bus.f_stat = bus.f_imem_error ? S_ADR : !bus.f_instr_valid ? S_INS : bus.f_hlt ? S_HLT : S_AOK;
  end
  // pipeline controls, prediction and drain sequencing; HALTED freezes everything
  always_comb begin
    bus.F_stall = loaduse | retpend | (state != RUN);
    bus.D_stall = halt | loaduse;
    bus.D_bubble = !halt & (mispred | (!loaduse & retpend) | (state == DRAIN));
    bus.E_bubble = halt | mispred | loaduse;
    pred_pc_nxt = bus.F_stall ? pred_pc :
                  (bus.f_icode == I_JXX || bus.f_icode == I_CALL) ? bus.f_valC : bus.f_valP;
    state_nxt = (state == RUN && !bus.F_stall && bus.f_stat != S_AOK && !mispred) ? DRAIN :
                (state == DRAIN && bus.W_stat != S_AOK) ? HALTED :
                (state == DRAIN && mispred) ? RUN : state;
  end
  // state and predicted-PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pred_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pred_pc <= pred_pc_nxt;
    end
  end
`ifdef FETCH_CTRL_PERF_EN
  // saturating event counters, frozen once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
      perf_mispred <= '0;
      perf_ret <= '0;
    end else if (!halt) begin
      perf_cycles <= perf_cycles + {31'd0, ~&perf_cycles};
      perf_stalls <= perf_stalls + {31'd0, bus.F_stall && state == RUN && ~&perf_stalls};
      perf_mispred <= perf_mispred + {31'd0, mispred && ~&perf_mispred};
      perf_ret <= perf_ret + {31'd0, retpend && ~&perf_ret};
    end
  end
`endif
endmodule
